// File: rtl/snd_rom_fetch.sv
`timescale 1ns/1ps
// Sound ROM read bridge: a CPU byte read maps either onto a one-cycle synchronous ROM or onto a fixed unmapped byte.
// Define SND_ROM_PREFETCH_EN to compile in a one-entry next-address prefetch buffer.
module snd_rom_fetch #(
    parameter logic [3:0] ROM_BASE      = 4'hF,
    parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        cpu_req_i,
    input  logic [15:0] cpu_addr_i,
    output logic        cpu_ready_o,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_data_o,
    output logic [11:0] rom_address_o,
    input  logic [7:0]  rom_data_i,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_PFCAP = 3'd4
    } state_t;

    state_t state;

    // Handshake: a read is accepted on any cycle with cpu_req_i && cpu_ready_o; cpu_addr_i is
    // sampled only then. The result is signalled by a single-cycle cpu_ack_o pulse with cpu_data_o
    // valid in that cycle. Requests outside IDLE are ignored, so the requester holds req/addr.
    assign cpu_ready_o = (state == S_IDLE);
    assign state_o     = state;

`ifdef SND_ROM_PREFETCH_EN
    logic [11:0] pf_addr;
    logic [7:0]  pf_data;
    logic        pf_valid;
    logic        pf_fill;
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= S_IDLE;
            cpu_ack_o     <= 1'b0;
            cpu_data_o    <= 8'h00;
            rom_address_o <= 12'h000;
`ifdef SND_ROM_PREFETCH_EN
            pf_addr       <= 12'h000;
            pf_data       <= 8'h00;
            pf_valid      <= 1'b0;
            pf_fill       <= 1'b0;
`endif
        end else begin
            cpu_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        if (cpu_addr_i[15:12] != ROM_BASE) begin
                            cpu_data_o <= UNMAPPED_DATA;
                            cpu_ack_o  <= 1'b1;
                            state      <= S_ACK;
`ifdef SND_ROM_PREFETCH_EN
                            pf_fill    <= 1'b0;
                        end else if (pf_valid && (cpu_addr_i[11:0] == pf_addr)) begin
                            // Hit: answer from the buffer and start fetching the following byte.
                            cpu_data_o    <= pf_data;
                            cpu_ack_o     <= 1'b1;
                            rom_address_o <= pf_addr + 12'd1;
                            pf_addr       <= pf_addr + 12'd1;
                            pf_valid      <= 1'b0;
                            pf_fill       <= 1'b1;
                            state         <= S_ACK;
`endif
                        end else begin
                            rom_address_o <= cpu_addr_i[11:0];
                            state         <= S_ADDR;
                        end
                    end
                end
                S_ADDR: state <= S_DATA;
                S_DATA: begin
                    cpu_data_o <= rom_data_i;
                    cpu_ack_o  <= 1'b1;
                    state      <= S_ACK;
`ifdef SND_ROM_PREFETCH_EN
                    // rom_address_o still holds the address just read, so +1 is the next byte.
                    rom_address_o <= rom_address_o + 12'd1;
                    pf_addr       <= rom_address_o + 12'd1;
                    pf_valid      <= 1'b0;
                    pf_fill       <= 1'b1;
`endif
                end
                S_ACK: begin
`ifdef SND_ROM_PREFETCH_EN
                    state <= pf_fill ? S_PFCAP : S_IDLE;
`else
                    state <= S_IDLE;
`endif
                end
                S_PFCAP: begin
`ifdef SND_ROM_PREFETCH_EN
                    pf_data  <= rom_data_i;
                    pf_valid <= 1'b1;
                    pf_fill  <= 1'b0;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snd_rom_fetch.sv
`timescale 1ns/1ps
// Directed bench for snd_rom_fetch with a behavioural one-cycle synchronous ROM; works with or
// without SND_ROM_PREFETCH_EN defined.
module tb_snd_rom_fetch;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        cpu_req_i;
    logic [15:0] cpu_addr_i;
    logic        cpu_ready_o;
    logic        cpu_ack_o;
    logic [7:0]  cpu_data_o;
    logic [11:0] rom_address_o;
    logic [7:0]  rom_data;
    logic [2:0]  state_o;

`ifdef SND_ROM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int HIT_LAT = PF ? 1 : 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;

    logic [7:0] rom [0:4095];

    int n_vec = 0;
    int n_err = 0;

    snd_rom_fetch dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_ready_o   (cpu_ready_o),
        .cpu_ack_o     (cpu_ack_o),
        .cpu_data_o    (cpu_data_o),
        .rom_address_o (rom_address_o),
        .rom_data_i    (rom_data),
        .state_o       (state_o)
    );

    // clock / ROM model
    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) rom_data <= rom[rom_address_o];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Issues one read and returns in the ack cycle (or after the bound expires).
    task automatic do_read(input logic [15:0] addr, input logic [7:0] exp_data,
                           input int exp_lat, input string tag);
        int waited = 0;
        int lat;
        while (!cpu_ready_o && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " ready"}, cpu_ready_o, 1);
        cpu_req_i  = 1'b1;
        cpu_addr_i = addr;
        tick();
        cpu_req_i = 1'b0;
        lat = 1;
        while (!cpu_ack_o && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " data"}, cpu_data_o, exp_data);
    endtask

    initial begin
        int acks;
        int gap;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h123] = 8'h5A;
        rom[12'h124] = 8'h42;
        rom[12'h130] = 8'h77;
        rom[12'h200] = 8'h11;
        rom[12'h201] = 8'hC3;
        rom[12'hFFF] = 8'hE1;
        rom[12'h000] = 8'h3C;
        rom[12'h050] = 8'h96;

        // reset
        reset_n_i  = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_addr_i = 16'h0000;
        tick(); tick(); tick();
        check("rst ack", cpu_ack_o, 0);
        check("rst data", cpu_data_o, 8'h00);
        check("rst rom_addr", rom_address_o, 12'h000);
        reset_n_i = 1'b1;
        check("post-rst ready", cpu_ready_o, 1);
        check("post-rst state", state_o, ST_IDLE);

        // mapped miss timing, cycle by cycle
        cpu_req_i  = 1'b1;
        cpu_addr_i = 16'hF123;
        tick();
        cpu_req_i = 1'b0;
        check("miss N+1 rom_addr", rom_address_o, 12'h123);
        check("miss N+1 state", state_o, ST_ADDR);
        check("miss N+1 ready", cpu_ready_o, 0);
        tick();
        check("miss N+2 ack", cpu_ack_o, 0);
        check("miss N+2 state", state_o, ST_DATA);
        tick();
        check("miss N+3 ack", cpu_ack_o, 1);
        check("miss N+3 data", cpu_data_o, 8'h5A);
        tick();
        check("miss N+4 ack", cpu_ack_o, 0);
        check("miss N+4 ready", cpu_ready_o, PF ? 0 : 1);
        check("miss N+4 data held", cpu_data_o, 8'h5A);
        if (PF) begin
            tick();
            check("miss N+5 ready", cpu_ready_o, 1);
        end

        // unmapped read leaves the ROM address alone
        do_read(16'h1234, 8'hFF, 1, "unmapped");
        check("unmapped rom_addr", rom_address_o, PF ? 12'h124 : 12'h123);
        tick();
        check("unmapped ack 1 cycle", cpu_ack_o, 0);
        check("unmapped rom_addr hold", rom_address_o, PF ? 12'h124 : 12'h123);

        // sequential reads: second one hits the prefetch when compiled in
        do_read(16'hF200, 8'h11, 3, "seq F200");
        do_read(16'hF201, 8'hC3, HIT_LAT, "seq F201");
        check("seq rom_addr", rom_address_o, PF ? 12'h202 : 12'h201);

        // wrap at the top of the ROM
        do_read(16'hFFFF, 8'hE1, 3, "wrap FFFF");
        check("wrap rom_addr", rom_address_o, PF ? 12'h000 : 12'hFFF);
        do_read(16'hF000, 8'h3C, HIT_LAT, "wrap F000");
        do_read(16'hF050, 8'h96, 3, "mismatch F050");
        do_read(16'hF123, 8'h5A, 3, "refill F123");

        // reset during DATA of a miss discards it
        tick(); tick(); tick();
        cpu_req_i  = 1'b1;
        cpu_addr_i = 16'hF130;
        tick();
        cpu_req_i = 1'b0;
        tick();
        check("rstmid state", state_o, ST_DATA);
        reset_n_i = 1'b0;
        #1;
        check("rstmid ack", cpu_ack_o, 0);
        check("rstmid data", cpu_data_o, 8'h00);
        check("rstmid rom_addr", rom_address_o, 12'h000);
        check("rstmid state idle", state_o, ST_IDLE);
        tick();
        reset_n_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack_o) acks++;
        end
        check("rstmid no ack", acks, 0);
        // a buffered 124 would have hit; after reset it must be a miss
        do_read(16'hF124, 8'h42, 3, "post-rstmid F124");

        // requester holds req with changing address
        tick(); tick(); tick();
        cpu_req_i  = 1'b1;
        cpu_addr_i = 16'hF123;
        tick();
        cpu_addr_i = 16'hF050;
        check("hold N+1 rom_addr", rom_address_o, 12'h123);
        tick();
        cpu_addr_i = 16'hF200;
        check("hold N+2 rom_addr", rom_address_o, 12'h123);
        tick();
        check("hold N+3 ack", cpu_ack_o, 1);
        check("hold N+3 data", cpu_data_o, 8'h5A);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!cpu_ack_o && gap < 20);
        cpu_req_i = 1'b0;
        check("hold gap", gap, PF ? 5 : 4);
        check("hold second data", cpu_data_o, 8'h11);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snd_rom_fetch.md
SND_ROM_FETCH -- requirements
Module: snd_rom_fetch

Interface
REQ-001 Parameter ROM_BASE, default 4'hF: cpu_addr_i[15:12] value that selects the sound ROM.
REQ-002 Parameter UNMAPPED_DATA, default 8'hFF: byte returned for reads outside ROM_BASE.
REQ-003 clock_i  in  1: single clock; all state on rising edge.
REQ-004 reset_n_i  in  1: asynchronous, active-low reset.
REQ-005 cpu_req_i  in  1: read request; accepted on a cycle where cpu_req_i && cpu_ready_o.
REQ-006 cpu_addr_i  in  16: CPU read address, sampled on the accept cycle only.
REQ-007 cpu_ready_o  out  1: high only in state IDLE.
REQ-008 cpu_ack_o  out  1: registered one-cycle pulse; cpu_data_o valid during it.
REQ-009 cpu_data_o  out  8: registered read data, held until the next ack.
REQ-010 rom_address_o  out  12: registered address to sound ROM.
REQ-011 rom_data_i  in  8: ROM output; valid the cycle after ROM samples rom_address_o (one-cycle synchronous ROM).

Function
REQ-012 States: IDLE, ADDR, DATA, ACK, PFCAP (PFCAP exists only with prefetch).
REQ-013 Mapped miss, accept in cycle N: edge N loads rom_address_o <= cpu_addr_i[11:0], goes ADDR; N+1 ROM samples; N+2 (DATA) rom_data_i captured into cpu_data_o; N+3 (ACK) cpu_ack_o=1; latency 3.
REQ-014 Unmapped (cpu_addr_i[15:12] != ROM_BASE): cpu_data_o <= UNMAPPED_DATA, go ACK directly, ack in N+1; no ROM access; rom_address_o unchanged.
REQ-015 ACK lasts exactly one cycle; exits to PFCAP (if entered from a ROM-sourced result with prefetch) else IDLE.
REQ-016 cpu_req_i high outside IDLE is ignored; no queuing; requester holds req/addr until ready.
REQ-017 A request in the IDLE cycle immediately following ACK/PFCAP is accepted normally (back-to-back allowed).
REQ-018 rom_address_o holds its last value whenever not being updated.

Reset
REQ-019 reset_n_i low asynchronously forces: state IDLE, cpu_ack_o=0, cpu_data_o=8'h00, rom_address_o=12'h000, prefetch valid=0; cpu_ready_o=1 while held low is not required (=0 permitted) but must be 1 the first cycle after release.
REQ-020 Reset mid-transaction discards the pending request; no ack is produced for it.

Configuration
REQ-021 Macro SND_ROM_PREFETCH_EN: when defined, a one-entry next-address prefetch buffer (pf_addr 12b, pf_data 8b, pf_valid) is compiled in; when undefined, none of it exists, PFCAP is unreachable and every mapped read follows REQ-013.
REQ-022 With prefetch: on every edge entering ACK from a ROM-sourced read of address A, rom_address_o <= A+1 mod 4096 (12'hFFF wraps to 12'h000), pf_addr <= A+1, pf_valid <= 0.
REQ-023 PFCAP (cycle after ACK): capture rom_data_i into pf_data, pf_valid <= 1, go IDLE; cpu_ready_o low in PFCAP.
REQ-024 Hit: mapped accept with pf_valid && cpu_addr_i[11:0]==pf_addr: cpu_data_o <= pf_data, go ACK, ack in N+1; then REQ-022 prefetch of pf_addr+1.
REQ-025 Unmapped reads leave pf_addr/pf_valid unchanged; mapped mismatches take the miss path and overwrite the prefetch per REQ-022.

Verification
REQ-026 Reset, then req addr 16'hF123 with ROM[0x123]=8'h5A -> rom_address_o=12'h123 in N+1, ack in N+3 with 8'h5A, ready high in N+4 (macro off) / N+5 (macro on).
REQ-027 Req 16'h1234 -> ack N+1, data 8'hFF, rom_address_o unchanged, no ROM address change.
REQ-028 Macro on: read F200 then F201 (ROM[0x201]=8'hC3) -> second ack one cycle after accept, data 8'hC3, rom_address_o becomes 12'h202.
REQ-029 Macro on: read FFFF then F000 -> prefetch wraps to 12'h000, F000 read is a hit with ROM[0x000].
REQ-030 Assert reset_n_i low in DATA cycle of a miss -> ack never asserted, cpu_data_o=8'h00, rom_address_o=12'h000, pf_valid=0; next request completes normally.
REQ-031 Hold cpu_req_i high continuously with changing addr during ADDR/DATA -> only the addr at accept is read; following request accepted only when ready_o=1.
